// File: rtl/counter4b_monitor.sv
// Self-checking consumer of a 4-bit up-counter interface: verifies +1 mod 16
// stepping and the ripple carry, reports violations while locked and counts wraps.
module counter4b_monitor #(
    parameter int LOCK_N = 2,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              Qa,
    input  logic              Qb,
    input  logic              Qc,
    input  logic              Qd,
    input  logic              Rc,
    output logic              locked,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WRAP_W-1:0] wraps
);

    typedef enum logic {SYNC = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [4:0] LOCK_V = 5'(LOCK_N);

    state_t            state_reg, state_next;
    logic [3:0]        q_prev_reg;
    logic              have_prev_reg;
    logic [3:0]        run_reg, run_next;
    logic              err_reg, err_next;
    logic [ERR_W-1:0]  err_cnt_reg, err_cnt_next;
    logic [WRAP_W-1:0] wraps_reg, wraps_next;

    logic [3:0] q;
    logic       good;
    logic       run_done;
    logic       wrap_seen;

    assign q         = {Qd, Qc, Qb, Qa};
    assign good      = have_prev_reg && (q == q_prev_reg + 4'd1) && (Rc == (q == 4'hF));
    assign run_done  = ({1'b0, run_reg} + 5'd1) == LOCK_V;
    assign wrap_seen = (q_prev_reg == 4'hF) && (q == 4'h0);

    // State and all outputs are registered; nothing combinational reaches a port.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_reg     <= SYNC;
            q_prev_reg    <= 4'd0;
            have_prev_reg <= 1'b0;
            run_reg       <= 4'd0;
            err_reg       <= 1'b0;
            err_cnt_reg   <= '0;
            wraps_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            q_prev_reg    <= q;
            have_prev_reg <= 1'b1;
            run_reg       <= run_next;
            err_reg       <= err_next;
            err_cnt_reg   <= err_cnt_next;
            wraps_reg     <= wraps_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SYNC:    if (good && run_done) state_next = LOCKED;
            LOCKED:  if (!good)            state_next = SYNC;
            default: state_next = SYNC;
        endcase
    end

    always_comb begin
        run_next     = 4'd0;
        err_next     = 1'b0;
        err_cnt_next = err_cnt_reg;
        wraps_next   = wraps_reg;
        case (state_reg)
            SYNC: begin
                if (good && !run_done) run_next = run_reg + 4'd1;
            end
            LOCKED: begin
                if (good) begin
                    if (wrap_seen) wraps_next = wraps_reg + 1'b1;
                end else begin
                    err_next = 1'b1;
                    if (!(&err_cnt_reg)) err_cnt_next = err_cnt_reg + 1'b1;
                end
            end
            default: run_next = 4'd0;
        endcase
    end

    assign locked  = (state_reg == LOCKED);
    assign err     = err_reg;
    assign err_cnt = err_cnt_reg;
    assign wraps   = wraps_reg;

endmodule

// File: tb/tb_counter4b_monitor.sv
// Randomized and directed bench for counter4b_monitor against an integer
// reference model of the monitor rules.
module tb_counter4b_monitor;

    localparam int LOCK_N = 2;
    localparam int WRAP_W = 8;
    localparam int ERR_W  = 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic              ck = 1'b0;
    logic              rst = 1'b1;
    logic              Qa = 1'b0, Qb = 1'b0, Qc = 1'b0, Qd = 1'b0, Rc = 1'b0;
    logic              locked, err;
    logic [ERR_W-1:0]  err_cnt;
    logic [WRAP_W-1:0] wraps;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_prev = 0, m_have = 0, m_run = 0, m_locked = 0, m_err = 0;
    int m_err_cnt = 0, m_wraps = 0;
    int cur = 0;

    counter4b_monitor #(.LOCK_N(LOCK_N), .WRAP_W(WRAP_W), .ERR_W(ERR_W)) dut (
        .ck(ck), .rst(rst), .Qa(Qa), .Qb(Qb), .Qc(Qc), .Qd(Qd), .Rc(Rc),
        .locked(locked), .err(err), .err_cnt(err_cnt), .wraps(wraps)
    );

    always #10 ck = ~ck;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input int qv, input int rcv, input int rv);
        int good;
        if (rv != 0) begin
            m_prev = 0; m_have = 0; m_run = 0; m_locked = 0; m_err = 0;
            m_err_cnt = 0; m_wraps = 0;
            return;
        end
        good = (m_have != 0) && (qv == ((m_prev + 1) % 16)) && (rcv == ((qv == 15) ? 1 : 0));
        m_err = 0;
        if (m_locked == 0) begin
            if (good) begin
                if (m_run + 1 == LOCK_N) begin m_locked = 1; m_run = 0; end
                else m_run = m_run + 1;
            end else m_run = 0;
        end else if (good) begin
            if (m_prev == 15 && qv == 0) m_wraps = (m_wraps + 1) % (1 << WRAP_W);
        end else begin
            m_err = 1; m_locked = 0; m_run = 0;
            if (m_err_cnt < ERR_MAX) m_err_cnt = m_err_cnt + 1;
        end
        m_prev = qv;
        m_have = 1;
    endtask

    task automatic step(input int qv, input int rcv, input int rv);
        @(negedge ck);
        {Qd, Qc, Qb, Qa} = 4'(qv);
        Rc  = (rcv != 0);
        rst = (rv != 0);
        @(posedge ck);
        model_edge(qv, rcv, rv);
        cur = qv;
        #1;
        check_val("locked",  int'(locked),  m_locked);
        check_val("err",     int'(err),     m_err);
        check_val("err_cnt", int'(err_cnt), m_err_cnt);
        check_val("wraps",   int'(wraps),   m_wraps);
        $display("step q=%0d rc=%0d rst=%0d -> locked=%0d err=%0d err_cnt=%0d wraps=%0d",
                 qv, rcv, rv, locked, err, err_cnt, wraps);
    endtask

    task automatic good_step();
        int nq;
        nq = (cur + 1) % 16;
        step(nq, (nq == 15) ? 1 : 0, 0);
    endtask

    // Advance with correct counts until locked with the last sample == target.
    task automatic advance_to(input int target);
        int n;
        n = 0;
        while ((cur != target || m_locked == 0) && n < 100) begin
            good_step();
            n++;
        end
        check_val("advance_budget", (n < 100) ? 1 : 0, 1);
    endtask

    initial begin
        // reset state
        step(0, 0, 1);
        step(0, 0, 1);
        check_val("reset_locked", int'(locked), 0);

        // lock-up from 0,1,2
        step(0, 0, 0);
        check_val("first_sample_unlocked", int'(locked), 0);
        step(1, 0, 0);
        check_val("second_sample_unlocked", int'(locked), 0);
        step(2, 0, 0);
        check_val("locked_on_3rd", int'(locked), 1);

        // 40 correct cycles
        for (int i = 0; i < 40; i++) good_step();
        check_val("wraps_after_40", int'(wraps), 2);

        // skip a value: 5,6,8
        advance_to(6);
        step(8, 0, 0);
        check_val("skip_err", int'(err), 1);
        step(9, 0, 0);
        check_val("skip_err_one_cycle", int'(err), 0);
        step(10, 0, 0);
        check_val("relock_after_skip", int'(locked), 1);

        // Rc wrong at 15, then 0 must not count a wrap
        advance_to(14);
        step(15, 0, 0);
        check_val("rc_err", int'(err), 1);
        step(0, 0, 0);
        check_val("no_wrap_after_violation", int'(wraps), m_wraps);

        // 300 violations (held count), relocking each time
        for (int i = 0; i < 300; i++) begin
            advance_to((cur + 1) % 16);
            step(cur, (cur == 15) ? 1 : 0, 0);
        end
        check_val("err_cnt_saturated", int'(err_cnt), ERR_MAX);

        // reset mid-lock at count 7, then resume 8,9,10
        advance_to(6);
        step(7, 0, 1);
        check_val("midlock_rst_locked", int'(locked), 0);
        check_val("midlock_rst_err_cnt", int'(err_cnt), 0);
        step(8, 0, 0);
        step(9, 0, 0);
        check_val("resume_not_yet", int'(locked), 0);
        step(10, 0, 0);
        check_val("resume_lock_at_10", int'(locked), 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r, nq;
            r  = $urandom_range(0, 19);
            nq = (cur + 1) % 16;
            case (r)
                0: step($urandom_range(0, 15), $urandom_range(0, 1), 0);
                1: step(nq, (nq == 15) ? 0 : 1, 0);
                2: step(cur, (cur == 15) ? 1 : 0, 0);
                3: step($urandom_range(0, 15), 0, 1);
                default: step(nq, (nq == 15) ? 1 : 0, 0);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
